// File: rtl/bus_if_pkg.sv
// Shared definitions for the PE-to-CGRA bus interface: op codes, FSM
// state encoding and the layout width of a queued request.
package bus_if_pkg;

    // PE request op codes, also driven unchanged onto bus_op.
    localparam logic [1:0] OP_MEM_RD = 2'b00;
    localparam logic [1:0] OP_MEM_WR = 2'b01;
    localparam logic [1:0] OP_REG_WR = 2'b10;
    localparam logic [1:0] OP_REG_RD = 2'b11;

    // Issue FSM states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // A queued request is {op, addr, wdata, rs1, rs2, rd}, MSB first.
    function automatic int req_width(input int addr_w, input int data_w, input int reg_aw);
        return 2 + addr_w + data_w + 3 * reg_aw;
    endfunction

    // Reads return data on the A lane; writes return zero.
    function automatic logic op_returns_a(input logic [1:0] op);
        return (op == OP_MEM_RD) || (op == OP_REG_RD);
    endfunction

    // Only register reads return data on the B lane.
    function automatic logic op_returns_b(input logic [1:0] op);
        return op == OP_REG_RD;
    endfunction

endpackage

// File: rtl/bus_req_fifo.sv
// Synchronous request queue. Depth must be a power of two so that the
// read/write pointers wrap naturally at their bit width.
module bus_req_fifo
    import bus_if_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    // A full queue never takes a push, even if it is popped this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next pointer and occupancy values.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; an emptied queue never exposes stale entries, since count gates every read.
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/bus_interface_q.sv
// PE-side bus interface: queues PE requests, issues them one at a time
// under a request/grant handshake and returns exactly one response per
// request, with an optional timeout against an unresponsive target.
module bus_interface_q
    import bus_if_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pe_req_valid,
    output logic              pe_req_ready,
    input  logic [1:0]        pe_req_op,
    input  logic [ADDR_W-1:0] pe_req_addr,
    input  logic [DATA_W-1:0] pe_req_wdata,
    input  logic [REG_AW-1:0] pe_req_rs1,
    input  logic [REG_AW-1:0] pe_req_rs2,
    input  logic [REG_AW-1:0] pe_req_rd,
    output logic              pe_rsp_valid,
    input  logic              pe_rsp_ready,
    output logic [DATA_W-1:0] pe_rsp_data_a,
    output logic [DATA_W-1:0] pe_rsp_data_b,
    output logic              pe_rsp_err,
    output logic              bus_request,
    input  logic              grant,
    output logic              bus_valid,
    output logic [1:0]        bus_op,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [REG_AW-1:0] bus_rs1,
    output logic [REG_AW-1:0] bus_rs2,
    output logic [REG_AW-1:0] bus_rd,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata_a,
    input  logic [DATA_W-1:0] bus_rdata_b
);

    localparam int REQ_W = req_width(ADDR_W, DATA_W, REG_AW);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    // Request queue.
    logic [REQ_W-1:0]            fifo_din;
    logic [REQ_W-1:0]            fifo_dout;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        fifo_pop;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        unused_fifo_count;

    // Head-of-queue fields.
    logic [1:0]        head_op;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;
    logic [REG_AW-1:0] head_rs1, head_rs2, head_rd;

    // FSM, command register, timeout counter and registered outputs.
    logic [1:0]        state_q, state_d;
    logic [1:0]        cmd_op_q, cmd_op_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [REG_AW-1:0] cmd_rs1_q, cmd_rs1_d;
    logic [REG_AW-1:0] cmd_rs2_q, cmd_rs2_d;
    logic [REG_AW-1:0] cmd_rd_q, cmd_rd_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              bus_request_q, bus_request_d;
    logic              bus_valid_q, bus_valid_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_a_q, rsp_data_a_d;
    logic [DATA_W-1:0] rsp_data_b_q, rsp_data_b_d;
    logic              rsp_err_q, rsp_err_d;
    logic              timed_out;

    assign fifo_din = {pe_req_op, pe_req_addr, pe_req_wdata, pe_req_rs1, pe_req_rs2, pe_req_rd};
    assign {head_op, head_addr, head_wdata, head_rs1, head_rs2, head_rd} = fifo_dout;
    // Occupancy is kept on the queue for observability only.
    assign unused_fifo_count = ^fifo_count;

    bus_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pe_req_valid),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign pe_req_ready  = !fifo_full;
    assign pe_rsp_valid  = rsp_valid_q;
    assign pe_rsp_data_a = rsp_data_a_q;
    assign pe_rsp_data_b = rsp_data_b_q;
    assign pe_rsp_err    = rsp_err_q;
    assign bus_request   = bus_request_q;
    assign bus_valid     = bus_valid_q;
    assign bus_op        = cmd_op_q;
    assign bus_addr      = cmd_addr_q;
    assign bus_wdata     = cmd_wdata_q;
    assign bus_rs1       = cmd_rs1_q;
    assign bus_rs2       = cmd_rs2_q;
    assign bus_rd        = cmd_rd_q;

    // Timeout fires on the last waiting cycle; TIMEOUT of 0 never fires.
    assign timed_out = (TIMEOUT != 0) && (wait_cnt_q == CNT_W'(TIMEOUT - 1));

    // Issue FSM: pop, request, transfer, then hold the response for the PE.
    always_comb begin
        state_d       = state_q;
        cmd_op_d      = cmd_op_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_wdata_d   = cmd_wdata_q;
        cmd_rs1_d     = cmd_rs1_q;
        cmd_rs2_d     = cmd_rs2_q;
        cmd_rd_d      = cmd_rd_q;
        wait_cnt_d    = wait_cnt_q;
        bus_request_d = bus_request_q;
        bus_valid_d   = bus_valid_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_a_d  = rsp_data_a_q;
        rsp_data_b_d  = rsp_data_b_q;
        rsp_err_d     = rsp_err_q;
        fifo_pop      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    cmd_op_d      = head_op;
                    cmd_addr_d    = head_addr;
                    cmd_wdata_d   = head_wdata;
                    cmd_rs1_d     = head_rs1;
                    cmd_rs2_d     = head_rs2;
                    cmd_rd_d      = head_rd;
                    bus_request_d = 1'b1;
                    state_d       = ST_REQ;
                end
            end
            ST_REQ: begin
                if (grant) begin
                    bus_valid_d = 1'b1;
                    wait_cnt_d  = '0;
                    state_d     = ST_XFER;
                end
            end
            ST_XFER: begin
                // Ack takes priority over a simultaneous timeout.
                if (bus_ack) begin
                    rsp_data_a_d  = op_returns_a(cmd_op_q) ? bus_rdata_a : '0;
                    rsp_data_b_d  = op_returns_b(cmd_op_q) ? bus_rdata_b : '0;
                    rsp_err_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    bus_request_d = 1'b0;
                    bus_valid_d   = 1'b0;
                    state_d       = ST_RESP;
                end else if (timed_out) begin
                    rsp_data_a_d  = '0;
                    rsp_data_b_d  = '0;
                    rsp_err_d     = 1'b1;
                    rsp_valid_d   = 1'b1;
                    bus_request_d = 1'b0;
                    bus_valid_d   = 1'b0;
                    state_d       = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (pe_rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                    rsp_data_a_d = '0;
                    rsp_data_b_d = '0;
                    rsp_err_d    = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
        endcase
    end

    // FSM, command and response registers; reset abandons any transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cmd_op_q      <= '0;
            cmd_addr_q    <= '0;
            cmd_wdata_q   <= '0;
            cmd_rs1_q     <= '0;
            cmd_rs2_q     <= '0;
            cmd_rd_q      <= '0;
            wait_cnt_q    <= '0;
            bus_request_q <= 1'b0;
            bus_valid_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_a_q  <= '0;
            rsp_data_b_q  <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_op_q      <= cmd_op_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_wdata_q   <= cmd_wdata_d;
            cmd_rs1_q     <= cmd_rs1_d;
            cmd_rs2_q     <= cmd_rs2_d;
            cmd_rd_q      <= cmd_rd_d;
            wait_cnt_q    <= wait_cnt_d;
            bus_request_q <= bus_request_d;
            bus_valid_q   <= bus_valid_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_a_q  <= rsp_data_a_d;
            rsp_data_b_q  <= rsp_data_b_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_bus_interface_q.sv
// Directed bench for bus_interface_q with default parameters.
module tb_bus_interface_q;

    logic        clk = 1'b0;
    logic        reset;
    logic        pe_req_valid;
    logic        pe_req_ready;
    logic [1:0]  pe_req_op;
    logic [31:0] pe_req_addr;
    logic [31:0] pe_req_wdata;
    logic [4:0]  pe_req_rs1, pe_req_rs2, pe_req_rd;
    logic        pe_rsp_valid;
    logic        pe_rsp_ready;
    logic [31:0] pe_rsp_data_a, pe_rsp_data_b;
    logic        pe_rsp_err;
    logic        bus_request;
    logic        grant;
    logic        bus_valid;
    logic [1:0]  bus_op;
    logic [31:0] bus_addr, bus_wdata;
    logic [4:0]  bus_rs1, bus_rs2, bus_rd;
    logic        bus_ack;
    logic [31:0] bus_rdata_a, bus_rdata_b;

    int total = 0;
    int bad   = 0;

    bus_interface_q dut (
        .clk           (clk),
        .reset         (reset),
        .pe_req_valid  (pe_req_valid),
        .pe_req_ready  (pe_req_ready),
        .pe_req_op     (pe_req_op),
        .pe_req_addr   (pe_req_addr),
        .pe_req_wdata  (pe_req_wdata),
        .pe_req_rs1    (pe_req_rs1),
        .pe_req_rs2    (pe_req_rs2),
        .pe_req_rd     (pe_req_rd),
        .pe_rsp_valid  (pe_rsp_valid),
        .pe_rsp_ready  (pe_rsp_ready),
        .pe_rsp_data_a (pe_rsp_data_a),
        .pe_rsp_data_b (pe_rsp_data_b),
        .pe_rsp_err    (pe_rsp_err),
        .bus_request   (bus_request),
        .grant         (grant),
        .bus_valid     (bus_valid),
        .bus_op        (bus_op),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_rs1       (bus_rs1),
        .bus_rs2       (bus_rs2),
        .bus_rd        (bus_rd),
        .bus_ack       (bus_ack),
        .bus_rdata_a   (bus_rdata_a),
        .bus_rdata_b   (bus_rdata_b)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1 ns past it; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        pe_req_valid = 1'b1;
        pe_req_op    = op;
        pe_req_addr  = addr;
        pe_req_wdata = wdata;
        pe_req_rs1   = rs1;
        pe_req_rs2   = rs2;
        pe_req_rd    = rd;
        tick();
        pe_req_valid = 1'b0;
    endtask

    task automatic wait_bus_valid(input string tag);
        int n = 0;
        while (bus_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_issue"}, 64'(bus_valid), 64'd1);
    endtask

    task automatic ack(input logic [31:0] a, input logic [31:0] b);
        bus_ack     = 1'b1;
        bus_rdata_a = a;
        bus_rdata_b = b;
        tick();
        bus_ack     = 1'b0;
        bus_rdata_a = '0;
        bus_rdata_b = '0;
    endtask

    task automatic accept(input string tag);
        pe_rsp_ready = 1'b1;
        tick();
        pe_rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, 64'(pe_rsp_valid), 64'd0);
    endtask

    initial begin
        int cyc;
        reset        = 1'b1;
        pe_req_valid = 1'b0;
        pe_req_op    = '0;
        pe_req_addr  = '0;
        pe_req_wdata = '0;
        pe_req_rs1   = '0;
        pe_req_rs2   = '0;
        pe_req_rd    = '0;
        pe_rsp_ready = 1'b0;
        grant        = 1'b1;
        bus_ack      = 1'b0;
        bus_rdata_a  = '0;
        bus_rdata_b  = '0;
        tick();
        tick();
        check("rst_ready", 64'(pe_req_ready), 64'd1);
        check("rst_req", 64'(bus_request), 64'd0);
        check("rst_valid", 64'(bus_valid), 64'd0);
        check("rst_rsp", 64'(pe_rsp_valid), 64'd0);
        check("rst_addr", 64'(bus_addr), 64'd0);
        reset = 1'b0;
        tick();

        // MEM_WR with exact latency and ack two cycles after bus_valid.
        push(2'b01, 32'hAABBCCDD, 32'h12345678, 5'd0, 5'd0, 5'd0);
        check("wr_req_n", 64'(bus_request), 64'd0);
        tick();
        check("wr_req_n1", 64'(bus_request), 64'd1);
        check("wr_valid_n1", 64'(bus_valid), 64'd0);
        tick();
        check("wr_valid_n2", 64'(bus_valid), 64'd1);
        check("wr_op", 64'(bus_op), 64'd1);
        check("wr_addr", 64'(bus_addr), 64'hAABBCCDD);
        check("wr_wdata", 64'(bus_wdata), 64'h12345678);
        tick();
        check("wr_hold", 64'(bus_valid), 64'd1);
        ack(32'hDEADBEEF, 32'hCAFEF00D);
        check("wr_rsp", 64'(pe_rsp_valid), 64'd1);
        check("wr_data_a", 64'(pe_rsp_data_a), 64'd0);
        check("wr_err", 64'(pe_rsp_err), 64'd0);
        check("wr_req_drop", 64'(bus_request), 64'd0);
        check("wr_valid_drop", 64'(bus_valid), 64'd0);
        tick();
        check("wr_rsp_hold", 64'(pe_rsp_valid), 64'd1);
        accept("wr");

        // MEM_RD returns A lane only.
        push(2'b00, 32'h11223344, 32'h0, 5'd0, 5'd0, 5'd0);
        wait_bus_valid("rd");
        check("rd_op", 64'(bus_op), 64'd0);
        check("rd_addr", 64'(bus_addr), 64'h11223344);
        ack(32'h87654321, 32'h0000FFFF);
        check("rd_data_a", 64'(pe_rsp_data_a), 64'h87654321);
        check("rd_data_b", 64'(pe_rsp_data_b), 64'd0);
        check("rd_err", 64'(pe_rsp_err), 64'd0);
        accept("rd");

        // REG_RD returns both lanes.
        push(2'b11, 32'h0, 32'h0, 5'd1, 5'd2, 5'd0);
        wait_bus_valid("rr");
        check("rr_op", 64'(bus_op), 64'd3);
        check("rr_rs1", 64'(bus_rs1), 64'd1);
        check("rr_rs2", 64'(bus_rs2), 64'd2);
        ack(32'hABCD1234, 32'hDCBA4321);
        check("rr_data_a", 64'(pe_rsp_data_a), 64'hABCD1234);
        check("rr_data_b", 64'(pe_rsp_data_b), 64'hDCBA4321);
        accept("rr");

        // REG_WR returns zero data even when the target drives data.
        push(2'b10, 32'h0, 32'h5A5A0001, 5'd0, 5'd0, 5'd31);
        wait_bus_valid("rw");
        check("rw_rd", 64'(bus_rd), 64'd31);
        check("rw_wdata", 64'(bus_wdata), 64'h5A5A0001);
        ack(32'h11111111, 32'h22222222);
        check("rw_data_a", 64'(pe_rsp_data_a), 64'd0);
        check("rw_data_b", 64'(pe_rsp_data_b), 64'd0);
        accept("rw");

        // Five back-to-back pushes with grant low: one popped, four fill the queue.
        grant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fill_ready%0d", i), 64'(pe_req_ready), 64'd1);
            push(2'b00, 32'h100 + 32'(i), 32'h0, 5'd0, 5'd0, 5'd0);
        end
        check("fill_full", 64'(pe_req_ready), 64'd0);
        tick();
        check("fill_req", 64'(bus_request), 64'd1);
        check("fill_novalid", 64'(bus_valid), 64'd0);
        grant = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_bus_valid($sformatf("ord%0d", i));
            check($sformatf("ord%0d_addr", i), 64'(bus_addr), 64'h100 + 64'(i));
            ack(32'hD0 + 32'(i), 32'h0);
            check($sformatf("ord%0d_data", i), 64'(pe_rsp_data_a), 64'hD0 + 64'(i));
            accept($sformatf("ord%0d", i));
        end

        // Timeout: bus_valid held exactly 16 cycles, then error response; next request proceeds.
        push(2'b00, 32'h55, 32'h0, 5'd0, 5'd0, 5'd0);
        push(2'b01, 32'h66, 32'h77, 5'd0, 5'd0, 5'd0);
        wait_bus_valid("to");
        cyc = 0;
        while (bus_valid === 1'b1 && cyc < 40) begin
            cyc++;
            tick();
        end
        check("to_cycles", 64'(cyc), 64'd16);
        check("to_rsp", 64'(pe_rsp_valid), 64'd1);
        check("to_err", 64'(pe_rsp_err), 64'd1);
        check("to_data", 64'(pe_rsp_data_a), 64'd0);
        accept("to");
        wait_bus_valid("after_to");
        check("after_to_addr", 64'(bus_addr), 64'h66);
        check("after_to_op", 64'(bus_op), 64'd1);
        ack(32'h0, 32'h0);
        check("after_to_err", 64'(pe_rsp_err), 64'd0);
        accept("after_to");

        // Reset mid-transfer with a request still queued.
        push(2'b00, 32'h99, 32'h0, 5'd0, 5'd0, 5'd0);
        push(2'b00, 32'h9A, 32'h0, 5'd0, 5'd0, 5'd0);
        wait_bus_valid("mid");
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 64'(bus_valid), 64'd0);
        check("mid_rst_req", 64'(bus_request), 64'd0);
        check("mid_rst_addr", 64'(bus_addr), 64'd0);
        check("mid_rst_ready", 64'(pe_req_ready), 64'd1);
        tick();
        reset   = 1'b0;
        bus_ack = 1'b1;
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus_request === 1'b1 || pe_rsp_valid === 1'b1) cyc++;
        end
        bus_ack = 1'b0;
        check("post_rst_quiet", 64'(cyc), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
